// File: rtl/fft_frame_sequencer_if.sv
// Bundle of the host sample stream, FFT sample/config streams, SVM result monitor
// and status outputs around the FFT frame sequencer.
interface fft_frame_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int CFG_W  = 16
);
    logic [CFG_W-1:0]  cfg_word;
    logic              cfg_update;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic [CFG_W-1:0]  m_cfg_tdata;
    logic              m_cfg_tvalid;
    logic              m_cfg_tready;
    logic              res_tvalid;
    logic              res_tready;
    logic              res_tlast;
    logic [3:0]        inflight;
    logic [31:0]       frames_sent;
    logic [31:0]       results_recv;
    logic [31:0]       pad_frames;
    logic              err_underflow;
    logic              busy;

    modport master (
        output cfg_word, cfg_update,
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output m_axis_tready, m_cfg_tready,
        output res_tvalid, res_tready, res_tlast,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_cfg_tdata, m_cfg_tvalid,
        input  inflight, frames_sent, results_recv, pad_frames, err_underflow, busy
    );

    modport slave (
        input  cfg_word, cfg_update,
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  m_axis_tready, m_cfg_tready,
        input  res_tvalid, res_tready, res_tlast,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_cfg_tdata, m_cfg_tvalid,
        output inflight, frames_sent, results_recv, pad_frames, err_underflow, busy
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Issues the FFT config word, slices the host stream into FFT_LEN frames with
// zero padding of short frames, and bounds frames in flight by SVM result credits.
module fft_frame_sequencer #(
    parameter int FFT_LEN      = 1024,
    parameter int MAX_INFLIGHT = 4,
    parameter int DATA_W       = 32,
    parameter int CFG_W        = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    fft_frame_sequencer_if.slave  bus
);
    localparam int              CNT_W    = $clog2(FFT_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FFT_LEN - 1);
    localparam logic [3:0]      MAX_CR   = 4'(MAX_INFLIGHT);

    localparam logic [1:0] S_CFG    = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_PAD    = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_live;
    logic             r_cfg_pending;
    logic [CFG_W-1:0] r_cfg_data;
    logic [3:0]       r_inflight;
    logic [31:0]      r_frames;
    logic [31:0]      r_results;
    logic [31:0]      r_pads;
    logic             r_err;

    logic              w_stream;
    logic              w_pad;
    logic              w_cfg_valid;
    logic              w_cfg_hs;
    logic              w_last_beat;
    logic              w_m_valid;
    logic              w_xfer;
    logic              w_complete;
    logic              w_res_done;
    logic [DATA_W-1:0] w_m_data;

    assign w_stream    = (r_state == S_STREAM);
    assign w_pad       = (r_state == S_PAD);
    // r_live holds config valid low for the first cycle after reset while cfg_word is captured
    assign w_cfg_valid = (r_state == S_CFG) && r_live;
    assign w_cfg_hs    = w_cfg_valid && bus.m_cfg_tready;
    assign w_last_beat = (r_cnt == LAST_CNT);
    assign w_m_valid   = w_stream ? bus.s_axis_tvalid : w_pad;
    assign w_m_data    = w_stream ? bus.s_axis_tdata : '0;
    assign w_xfer      = w_m_valid && bus.m_axis_tready;
    assign w_complete  = w_xfer && w_last_beat;
    assign w_res_done  = bus.res_tvalid && bus.res_tready && bus.res_tlast;

    assign bus.s_axis_tready = w_stream && bus.m_axis_tready;
    assign bus.m_axis_tdata  = w_m_data;
    assign bus.m_axis_tvalid = w_m_valid;
    assign bus.m_axis_tlast  = (w_stream || w_pad) && w_last_beat;
    assign bus.m_cfg_tdata   = r_cfg_data;
    assign bus.m_cfg_tvalid  = w_cfg_valid;
    assign bus.inflight      = r_inflight;
    assign bus.frames_sent   = r_frames;
    assign bus.results_recv  = r_results;
    assign bus.pad_frames    = r_pads;
    assign bus.err_underflow = r_err;
    assign bus.busy          = r_live && ((r_state != S_IDLE) || (r_inflight != 4'd0));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= S_CFG;
            r_cnt         <= '0;
            r_live        <= 1'b0;
            r_cfg_pending <= 1'b0;
            r_cfg_data    <= '0;
            r_inflight    <= 4'd0;
            r_frames      <= 32'd0;
            r_results     <= 32'd0;
            r_pads        <= 32'd0;
            r_err         <= 1'b0;
        end else begin
            r_live <= 1'b1;

            // a request landing while a config is already in CFG is absorbed by its handshake
            if (w_cfg_hs) begin
                r_cfg_pending <= 1'b0;
            end else if (bus.cfg_update) begin
                r_cfg_pending <= 1'b1;
            end

            case (r_state)
                S_CFG: begin
                    if (!r_live) begin
                        r_cfg_data <= bus.cfg_word;
                    end else if (w_cfg_hs) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (r_cfg_pending) begin
                        r_cfg_data <= bus.cfg_word;
                        r_state    <= S_CFG;
                    end else if (r_inflight < MAX_CR) begin
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last_beat) begin
                            r_state <= S_IDLE;
                        end else if (bus.s_axis_tlast) begin
                            r_pads  <= r_pads + 32'd1;
                            r_state <= S_PAD;
                        end
                    end
                end
                default: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last_beat) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase

            if (w_complete) begin
                r_frames <= r_frames + 32'd1;
            end
            if (w_res_done) begin
                r_results <= r_results + 32'd1;
            end

            case ({w_complete, w_res_done})
                2'b10: r_inflight <= r_inflight + 4'd1;
                2'b01: begin
                    if (r_inflight == 4'd0) begin
                        r_err <= 1'b1;
                    end else begin
                        r_inflight <= r_inflight - 4'd1;
                    end
                end
                default: r_inflight <= r_inflight;
            endcase
        end
    end
endmodule
